// File: rtl/uart_rx_framed.sv
// uart_rx_framed: UART receiver with input synchroniser, mid-bit sampling,
// optional parity, one or two stop bits, parity/framing error flags and a
// first-word-fall-through output FIFO with overrun reporting.
module uart_rx_framed #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY        = 0,
    parameter int NUM_STOP_BITS = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [NUM_DATA_BITS-1:0] o_data,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_overrun,
    output logic                     o_busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int WORD_W = NUM_DATA_BITS + 2;

    localparam logic [CNT_W-1:0] HALF_LAST     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA_IDX = 4'(NUM_DATA_BITS - 1);
    localparam logic             LAST_STOP_IDX = 1'(NUM_STOP_BITS - 1);
    localparam logic             ODD_PARITY    = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Parity mismatch of a received word against the configured sense.
    function automatic logic parity_err_f(input logic [NUM_DATA_BITS-1:0] d, input logic p);
        parity_err_f = ((^d) ^ p) != ODD_PARITY;
    endfunction

    logic                     sync1_r, sync2_r, rx_s;
    state_t                   state_r, state_next_s;
    logic [CNT_W-1:0]         cnt_r, cnt_next_s;
    logic [3:0]               bit_idx_r, bit_idx_next_s;
    logic                     stop_idx_r, stop_idx_next_s;
    logic [NUM_DATA_BITS-1:0] data_r, data_next_s;
    logic                     perr_r, perr_next_s;
    logic                     ferr_r, ferr_next_s;
    logic                     busy_r;
    logic                     push_s;
    logic [WORD_W-1:0]        push_word_s;

    logic [WORD_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r, rd_ptr_r;
    logic                     overrun_r;
    logic                     empty_s, full_s, pop_s, wr_en_s;
    logic [WORD_W-1:0]        head_s;

    assign rx_s = sync2_r;

    // Two-flop synchroniser on the asynchronous serial line, idling high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= i_rx;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, bit timing and frame assembly; the counter restarts on every state change.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r + CNT_W'(1);
        bit_idx_next_s  = bit_idx_r;
        stop_idx_next_s = stop_idx_r;
        data_next_s     = data_r;
        perr_next_s     = perr_r;
        ferr_next_s     = ferr_r;
        push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s      = '0;
                bit_idx_next_s  = 4'd0;
                stop_idx_next_s = 1'b0;
                perr_next_s     = 1'b0;
                ferr_next_s     = 1'b0;
                if (!rx_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_next_s = '0;
                    if (rx_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s  = '0;
                    // Shifting in from the top leaves the first bit at the LSB.
                    data_next_s = {rx_s, data_r[NUM_DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_DATA_IDX) begin
                        bit_idx_next_s = 4'd0;
                        state_next_s   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 4'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s   = '0;
                    perr_next_s  = parity_err_f(data_r, rx_s);
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s  = '0;
                    ferr_next_s = ferr_r | ~rx_s;
                    if (stop_idx_r == LAST_STOP_IDX) begin
                        push_s       = 1'b1;
                        state_next_s = ferr_next_s ? ST_BREAK : ST_IDLE;
                    end else begin
                        stop_idx_next_s = stop_idx_r + 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_next_s = '0;
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                cnt_next_s   = '0;
                state_next_s = ST_IDLE;
            end
        endcase
        push_word_s = {ferr_next_s, perr_r, data_r};
    end

    // Receiver state register; busy is registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            data_r     <= '0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            stop_idx_r <= stop_idx_next_s;
            data_r     <= data_next_s;
            perr_r     <= perr_next_s;
            ferr_r     <= ferr_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = !empty_s && i_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    // Output FIFO storage, pointers and the one-cycle overrun flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
                wr_ptr_r                <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            overrun_r <= push_s && full_s && !pop_s;
        end
    end

    assign o_valid      = !empty_s;
    assign o_data       = head_s[NUM_DATA_BITS-1:0];
    assign o_parity_err = head_s[NUM_DATA_BITS];
    assign o_frame_err  = head_s[NUM_DATA_BITS+1];
    assign o_overrun    = overrun_r;
    assign o_busy       = busy_r;

endmodule
